// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe referee.
package ttt_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned NUM_CELLS = 9;

  localparam logic [1:0] WHO_NONE = 2'b00;
  localparam logic [1:0] WHO_P1   = 2'b01;
  localparam logic [1:0] WHO_P2   = 2'b10;

  // Rows, columns, then the two diagonals; bit i = cell i, row-major.
  localparam logic [NUM_CELLS-1:0] WIN_MASK [0:7] = '{
    9'h007, 9'h038, 9'h1C0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

endpackage

// File: rtl/ttt_win_check.sv
// Combinational line detector: flags any win mask fully covered by the board.
module ttt_win_check
  import ttt_pkg::*;
(
  input  logic [NUM_CELLS-1:0] board,
  output logic                 win
);

  // OR together the eight full-line matches.
  always_comb begin
    win = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((board & WIN_MASK[i]) == WIN_MASK[i]) win = 1'b1;
    end
  end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe referee: validates moves, alternates turns, detects win/draw.
// state | meaning
// PLAY  | waiting for a move from the player in turn
// CHECK | one cycle: evaluate the mover's board for win / full board
// DONE  | game finished, outputs frozen until restart
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter logic FIRST_PLAYER = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 restart,
  input  logic                 move_valid,
  input  logic [3:0]           move_pos,
  output logic                 turn,
  output logic [1:0]           who,
  output logic                 draw,
  output logic                 game_over,
  output logic                 illegal,
  output logic [NUM_CELLS-1:0] board_p1,
  output logic [NUM_CELLS-1:0] board_p2,
  output logic [3:0]           move_cnt
);

  state_t                 state, state_n;
  logic                   turn_n, draw_n, game_over_n, illegal_n;
  logic [1:0]             who_n;
  logic [NUM_CELLS-1:0]   board_p1_n, board_p2_n;
  logic [3:0]             move_cnt_n;
  logic [NUM_CELLS-1:0]   cell_mask;
  logic                   cell_free;
  logic                   win;

  // Out-of-range positions shift the one-hot off the top, giving an empty mask.
  assign cell_mask = 9'(1) << move_pos;
  assign cell_free = (move_pos < 4'(NUM_CELLS)) && ((cell_mask & (board_p1 | board_p2)) == '0);

  ttt_win_check u_win_check (
    .board (turn ? board_p2 : board_p1),
    .win   (win)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PLAY;
      turn      <= FIRST_PLAYER;
      who       <= WHO_NONE;
      draw      <= 1'b0;
      game_over <= 1'b0;
      illegal   <= 1'b0;
      board_p1  <= '0;
      board_p2  <= '0;
      move_cnt  <= '0;
    end else begin
      state     <= state_n;
      turn      <= turn_n;
      who       <= who_n;
      draw      <= draw_n;
      game_over <= game_over_n;
      illegal   <= illegal_n;
      board_p1  <= board_p1_n;
      board_p2  <= board_p2_n;
      move_cnt  <= move_cnt_n;
    end
  end

  // Next-state and next-output decode; restart overrides everything.
  always_comb begin
    state_n     = state;
    turn_n      = turn;
    who_n       = who;
    draw_n      = draw;
    game_over_n = game_over;
    illegal_n   = 1'b0;
    board_p1_n  = board_p1;
    board_p2_n  = board_p2;
    move_cnt_n  = move_cnt;

    if (restart) begin
      state_n     = PLAY;
      turn_n      = FIRST_PLAYER;
      who_n       = WHO_NONE;
      draw_n      = 1'b0;
      game_over_n = 1'b0;
      board_p1_n  = '0;
      board_p2_n  = '0;
      move_cnt_n  = '0;
    end else begin
      case (state)
        PLAY: begin
          if (move_valid) begin
            if (!cell_free) begin
              illegal_n = 1'b1;
            end else begin
              if (turn) board_p2_n = board_p2 | cell_mask;
              else      board_p1_n = board_p1 | cell_mask;
              move_cnt_n = move_cnt + 4'd1;
              state_n    = CHECK;
            end
          end
        end
        CHECK: begin
          // Win is tested before the full board so a winning ninth move is a win.
          if (win) begin
            who_n       = turn ? WHO_P2 : WHO_P1;
            game_over_n = 1'b1;
            state_n     = DONE;
          end else if (move_cnt == 4'(NUM_CELLS)) begin
            draw_n      = 1'b1;
            game_over_n = 1'b1;
            state_n     = DONE;
          end else begin
            turn_n  = ~turn;
            state_n = PLAY;
          end
        end
        DONE: begin
          state_n = DONE;
        end
        default: begin
          state_n = PLAY;
        end
      endcase
    end
  end

endmodule
